// File: rtl/fir_pkg.sv
// Shared definitions for the parametrised AXI-Stream FIR: width helpers,
// the coefficient-bank address type and the round/saturate/wrap function.
package fir_pkg;

  localparam int MAX_TAPS = 64;
  localparam int MAX_W    = 128;

  // Ceiling log2, with clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Accumulator width: full product precision plus growth for NUM_TAPS terms.
  function automatic int acc_w(input int dw, input int cw, input int taps);
    return dw + cw + clog2(taps);
  endfunction

  // Wide enough to hold any tap index plus the out-of-range values 0..MAX_TAPS.
  typedef logic [clog2(MAX_TAPS):0] coef_addr_t;

  // Scale a sign-extended accumulator. With round_sat set: add half an LSB
  // (when shifting), arithmetic shift, clamp to the signed out_w range.
  // Without it: plain arithmetic shift; the caller keeps the low out_w bits.
  function automatic logic signed [MAX_W-1:0] scale_fit(
    input logic signed [MAX_W-1:0] acc,
    input int                      shift,
    input int                      out_w,
    input bit                      round_sat
  );
    logic signed [MAX_W-1:0] v;
    logic signed [MAX_W-1:0] one;
    logic signed [MAX_W-1:0] hi;
    logic signed [MAX_W-1:0] lo;
    one = {{(MAX_W-1){1'b0}}, 1'b1};
    v   = acc;
    if (round_sat && shift > 0) v = v + (one <<< (shift - 1));
    v = v >>> shift;
    if (round_sat) begin
      hi = (one <<< (out_w - 1)) - one;
      lo = ~hi;
      if (v > hi) v = hi;
      else if (v < lo) v = lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Double-buffered coefficient store. Writes always land in the shadow bank;
// a commit raises pending, and the shadow is copied to the active bank in
// the first cycle the datapath reports itself drained.
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int NUM_TAPS = 15,
  parameter int COEF_W   = 16,
  parameter int AW       = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             wr_en,
  input  logic [AW-1:0]                    addr,
  input  logic [COEF_W-1:0]                wdata,
  input  logic                             commit,
  input  logic                             drained,
  output logic                             pending,
  output logic [NUM_TAPS-1:0][COEF_W-1:0]  active
);

  logic [NUM_TAPS-1:0][COEF_W-1:0] shadow;
  coef_addr_t                      waddr;
  logic                            wr_ok;
  logic                            swap;

  assign waddr = coef_addr_t'(addr);
  assign wr_ok = wr_en && (waddr < coef_addr_t'(NUM_TAPS));
  assign swap  = pending & drained;

  // Shadow bank write port; out-of-range addresses are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) shadow <= '0;
    else if (wr_ok) shadow[addr] <= wdata;
  end

  // Swap copies the shadow as it was before any write in the same cycle;
  // a commit while already pending changes nothing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active  <= '0;
      pending <= 1'b0;
    end else if (swap) begin
      active  <= shadow;
      pending <= 1'b0;
    end else if (commit) begin
      pending <= 1'b1;
    end
  end

endmodule

// File: rtl/fir_axis_param.sv
// Parametrised, fully pipelined AXI-Stream FIR filter.
// Stages: S0 delay line, S1 per-tap products, S2 sum/scale/output register.
// Handshake: a beat moves when valid & ready are both high at a clock edge;
// a stalled output (valid & ~ready) freezes every stage and holds all
// output signals; input ready also drops while a coefficient swap waits.
// Optional macro FIR_ROUND_SAT_EN: round-half-up and saturate the output;
// without it the shifted accumulator is truncated and wrapped to OUT_W bits.
module fir_axis_param
  import fir_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int COEF_W   = 16,
  parameter int NUM_TAPS = 15,
  parameter int OUT_W    = 32,
  parameter int SHIFT    = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_W-1:0]            s_axis_fir_tdata,
  input  logic                         s_axis_fir_tvalid,
  input  logic                         s_axis_fir_tlast,
  output logic                         s_axis_fir_tready,
  output logic [OUT_W-1:0]             m_axis_fir_tdata,
  output logic                         m_axis_fir_tvalid,
  output logic                         m_axis_fir_tlast,
  output logic [OUT_W/8-1:0]           m_axis_fir_tkeep,
  input  logic                         m_axis_fir_tready,
  input  logic                         coef_wr_en,
  input  logic [clog2(NUM_TAPS)-1:0]   coef_addr,
  input  logic [COEF_W-1:0]            coef_wdata,
  input  logic                         coef_commit,
  output logic                         coef_pending
);

  localparam int AW     = clog2(NUM_TAPS);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = acc_w(DATA_W, COEF_W, NUM_TAPS);
`ifdef FIR_ROUND_SAT_EN
  localparam bit ROUND_SAT = 1'b1;
`else
  localparam bit ROUND_SAT = 1'b0;
`endif

  logic                              run;
  logic                              stall;
  logic                              accept;
  logic                              drained;
  logic                              v0, v1, l0, l1;
  logic [NUM_TAPS-1:0][DATA_W-1:0]   x;
  logic [NUM_TAPS-1:0][PROD_W-1:0]   p;
  logic [NUM_TAPS-1:0][COEF_W-1:0]   coefs;
  logic [ACC_W-1:0]                  acc;
  logic signed [MAX_W-1:0]           acc_ext;
  logic [OUT_W-1:0]                  fitted;

  assign stall             = m_axis_fir_tvalid & ~m_axis_fir_tready;
  assign s_axis_fir_tready = run & ~stall & ~coef_pending;
  assign accept            = s_axis_fir_tvalid & s_axis_fir_tready;
  assign drained           = ~v0 & ~v1 & ~m_axis_fir_tvalid;
  assign m_axis_fir_tkeep  = '1;

  fir_coef_bank #(
    .NUM_TAPS (NUM_TAPS),
    .COEF_W   (COEF_W),
    .AW       (AW)
  ) u_bank (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (coef_wr_en),
    .addr    (coef_addr),
    .wdata   (coef_wdata),
    .commit  (coef_commit),
    .drained (drained),
    .pending (coef_pending),
    .active  (coefs)
  );

  // Input ready is held low until the first cycle after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) run <= 1'b0;
    else        run <= 1'b1;
  end

  // S0: shift the delay line on accept only; history survives input gaps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x  <= '0;
      v0 <= 1'b0;
      l0 <= 1'b0;
    end else if (!stall) begin
      v0 <= accept;
      l0 <= accept & s_axis_fir_tlast;
      if (accept) x <= {x[NUM_TAPS-2:0], s_axis_fir_tdata};
    end
  end

  // S1: full-precision signed products of each tap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p  <= '0;
      v1 <= 1'b0;
      l1 <= 1'b0;
    end else if (!stall) begin
      v1 <= v0;
      l1 <= l0;
      for (int k = 0; k < NUM_TAPS; k++) begin
        p[k] <= $signed(coefs[k]) * $signed(x[k]);
      end
    end
  end

  // Sum of sign-extended products, then scale and fit to OUT_W.
  always_comb begin
    acc = '0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      acc = acc + {{(ACC_W-PROD_W){p[k][PROD_W-1]}}, p[k]};
    end
  end

  assign acc_ext = {{(MAX_W-ACC_W){acc[ACC_W-1]}}, acc};
  assign fitted  = OUT_W'(scale_fit(acc_ext, SHIFT, OUT_W, ROUND_SAT));

  // S2: output register, frozen while the consumer stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_axis_fir_tdata  <= '0;
      m_axis_fir_tvalid <= 1'b0;
      m_axis_fir_tlast  <= 1'b0;
    end else if (!stall) begin
      m_axis_fir_tdata  <= fitted;
      m_axis_fir_tvalid <= v1;
      m_axis_fir_tlast  <= v1 & l1;
    end
  end

endmodule

// File: tb/tb_fir_axis_param.sv
// Bench for fir_axis_param (default parameters). Expected outputs come from
// a direct convolution over the accepted-sample history and the coefficient
// set that is active when each sample is accepted.
module tb_fir_axis_param;

  localparam int DATA_W   = 16;
  localparam int COEF_W   = 16;
  localparam int NUM_TAPS = 15;
  localparam int OUT_W    = 32;
  localparam int SHIFT    = 0;
  localparam int AW       = 4;
`ifdef FIR_ROUND_SAT_EN
  localparam logic [OUT_W-1:0] SAT_EXP = 32'h7FFF_FFFF;
`else
  localparam logic [OUT_W-1:0] SAT_EXP = 32'hBFF1_000F;
`endif

  logic                clk;
  logic                reset;
  logic [DATA_W-1:0]   s_tdata;
  logic                s_tvalid;
  logic                s_tlast;
  logic                s_tready;
  logic [OUT_W-1:0]    m_tdata;
  logic                m_tvalid;
  logic                m_tlast;
  logic [OUT_W/8-1:0]  m_tkeep;
  logic                m_tready;
  logic                coef_wr_en;
  logic [AW-1:0]       coef_addr;
  logic [COEF_W-1:0]   coef_wdata;
  logic                coef_commit;
  logic                coef_pending;

  int total = 0;
  int bad   = 0;
  logic [OUT_W:0] exp_q[$];
  int  hist[NUM_TAPS];
  int  tb_active[NUM_TAPS];
  int  tb_shadow[NUM_TAPS];
  bit  bp_en = 0;
  int  last_cnt = 0;
  logic [OUT_W-1:0] last_out = '0;
  logic             prev_stall = 1'b0;
  logic [OUT_W:0]   prev_beat = '0;

  fir_axis_param #(
    .DATA_W   (DATA_W),
    .COEF_W   (COEF_W),
    .NUM_TAPS (NUM_TAPS),
    .OUT_W    (OUT_W),
    .SHIFT    (SHIFT)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .s_axis_fir_tdata  (s_tdata),
    .s_axis_fir_tvalid (s_tvalid),
    .s_axis_fir_tlast  (s_tlast),
    .s_axis_fir_tready (s_tready),
    .m_axis_fir_tdata  (m_tdata),
    .m_axis_fir_tvalid (m_tvalid),
    .m_axis_fir_tlast  (m_tlast),
    .m_axis_fir_tkeep  (m_tkeep),
    .m_axis_fir_tready (m_tready),
    .coef_wr_en        (coef_wr_en),
    .coef_addr         (coef_addr),
    .coef_wdata        (coef_wdata),
    .coef_commit       (coef_commit),
    .coef_pending      (coef_pending)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, expv);
    end
  endtask

  // Reference model
  function automatic int to_s16(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  function automatic logic [OUT_W-1:0] fit(input longint acc);
    longint v;
    v = acc;
`ifdef FIR_ROUND_SAT_EN
    begin
      longint hi;
      if (SHIFT > 0) v = v + (longint'(1) <<< (SHIFT > 0 ? SHIFT - 1 : 0));
      v  = v >>> SHIFT;
      hi = (longint'(1) <<< (OUT_W - 1)) - 1;
      if (v > hi) v = hi;
      else if (v < -hi - 1) v = -hi - 1;
    end
`else
    v = v >>> SHIFT;
`endif
    return v[OUT_W-1:0];
  endfunction

  task automatic model_accept(input logic [15:0] d, input bit l);
    longint s;
    for (int k = NUM_TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = to_s16(d);
    s = 0;
    for (int k = 0; k < NUM_TAPS; k++) s += longint'(tb_active[k]) * longint'(hist[k]);
    exp_q.push_back({l, fit(s)});
  endtask

  task automatic model_clear();
    for (int k = 0; k < NUM_TAPS; k++) begin
      hist[k] = 0;
      tb_active[k] = 0;
      tb_shadow[k] = 0;
    end
    exp_q.delete();
  endtask

  // Driver tasks: each returns 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    m_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic send(input logic [15:0] d, input bit l);
    int n;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    n = 0;
    @(negedge clk);
    while (!s_tready && n < 500) begin
      tick();
      @(negedge clk);
      n++;
    end
    check("accept", s_tready, 1);
    if (s_tready) model_accept(d, l);
    tick();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic write_coef(input int a, input logic [15:0] v);
    coef_wr_en = 1'b1;
    coef_addr  = a[AW-1:0];
    coef_wdata = v;
    tick();
    coef_wr_en = 1'b0;
    if (a < NUM_TAPS) tb_shadow[a] = to_s16(v);
  endtask

  task automatic commit_swap();
    int n;
    coef_commit = 1'b1;
    tick();
    coef_commit = 1'b0;
    check("pending_set", coef_pending, 1);
    n = 0;
    while (coef_pending && n < 500) begin
      check("ready_low_pending", s_tready, 0);
      tick();
      n++;
    end
    check("pending_clear", coef_pending, 0);
    check("ready_after_swap", s_tready, 1);
    tb_active = tb_shadow;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      tick();
      n++;
    end
    repeat (4) tick();
    check("drain_empty", exp_q.size(), 0);
  endtask

  // Scoreboard: compare every output beat, and output stability under stall.
  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", m_tvalid, 1);
        check("stall_hold", {m_tlast, m_tdata}, prev_beat);
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $error("FAIL unexpected_beat obs=%0h exp=none", {m_tlast, m_tdata});
        end else begin
          check("beat", {m_tlast, m_tdata}, exp_q.pop_front());
        end
        if (m_tlast) last_cnt++;
        last_out = m_tdata;
      end
      prev_stall = m_tvalid & ~m_tready;
      prev_beat  = {m_tlast, m_tdata};
    end
  end

  initial begin
    int lat;
    int r;
    reset = 1'b0;
    s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
    coef_wr_en = 1'b0; coef_addr = '0; coef_wdata = '0; coef_commit = 1'b0;
    model_clear();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_s_tready", s_tready, 0);
    check("rst_pending", coef_pending, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_m_tlast", m_tlast, 0);
    check("tkeep", m_tkeep, 4'hF);
    reset = 1'b1;
    tick();
    check("ready_after_rst", s_tready, 1);

    // Impulse response with c[k]=k+1; an out-of-range write must be ignored
    for (int k = 0; k < NUM_TAPS; k++) write_coef(k, 16'(k + 1));
    write_coef(15, 16'h7FFF);
    commit_swap();
    send(16'd1, 1'b0);
    lat = 0;
    while (!m_tvalid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 3);
    tick();
    for (int i = 0; i < 20; i++) send(16'd0, 1'b0);
    drain();
    check("impulse_tail", last_out, 0);

    // Random coefficients, 200-sample ramp under random backpressure
    for (int k = 0; k < NUM_TAPS; k++) write_coef(k, 16'($urandom_range(0, 65535)));
    commit_swap();
    bp_en = 1;
    for (int i = 0; i < 200; i++)
      send(16'(i * 300 - 30000 + int'($urandom_range(0, 50))), i == 199);
    drain();
    bp_en = 0;

    // 8-beat random packet with random input gaps, tlast on beat 8
    last_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      r = int'($urandom_range(0, 2));
      repeat (r) tick();
      send(16'($urandom_range(0, 65535)), i == 7);
    end
    drain();
    check("packet_last_cnt", last_cnt, 1);

    // Coefficient swap mid-stream: all-1 set to all-2 set, constant input 3
    for (int k = 0; k < NUM_TAPS; k++) write_coef(k, 16'd1);
    commit_swap();
    for (int k = 0; k < NUM_TAPS; k++) write_coef(k, 16'd2);
    bp_en = 1;
    for (int i = 0; i < 20; i++) send(16'd3, 1'b0);
    commit_swap();
    for (int i = 0; i < 20; i++) send(16'd3, 1'b0);
    drain();
    bp_en = 0;
    check("swap_settled", last_out, 90);

    // Saturation / wrap with full-scale coefficients and input
    for (int k = 0; k < NUM_TAPS; k++) write_coef(k, 16'h7FFF);
    commit_swap();
    for (int i = 0; i < 20; i++) send(16'h7FFF, 1'b0);
    drain();
    check("saturation", last_out, SAT_EXP);

    // Reset in the middle of a packet
    for (int k = 0; k < NUM_TAPS; k++) write_coef(k, 16'(k + 1));
    commit_swap();
    last_cnt = 0;
    for (int i = 0; i < 5; i++) send(16'(i + 7), 1'b0);
    reset = 1'b0;
    #1;
    check("midrst_m_tvalid", m_tvalid, 0);
    check("midrst_s_tready", s_tready, 0);
    check("midrst_m_tdata", m_tdata, 0);
    check("midrst_m_tlast", m_tlast, 0);
    check("midrst_pending", coef_pending, 0);
    model_clear();
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("midrst_ready_back", s_tready, 1);
    send(16'd5, 1'b0);
    drain();
    check("midrst_zero_coefs", last_out, 0);
    for (int k = 0; k < NUM_TAPS; k++) write_coef(k, 16'(k + 1));
    commit_swap();
    send(16'd1, 1'b0);
    send(16'd2, 1'b1);
    drain();
    check("midrst_new_only", last_out, 19);
    check("midrst_last_cnt", last_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
